// File: rtl/car_route_if.sv
// car_route_if: control/status bundle between the route controller and its surroundings.
interface car_route_if #(
  parameter int NUM_JUNCTIONS = 4
);
  logic                       start;
  logic                       abort;
  logic [2:0]                 sensor;
  logic [2*NUM_JUNCTIONS-1:0] route;
  logic [4:0]                 mode;
  logic [2:0]                 junction_idx;
  logic                       busy;
  modport master (output start, abort, sensor, route, input mode, junction_idx, busy);
  modport slave  (input start, abort, sensor, route, output mode, junction_idx, busy);
endinterface

// File: rtl/car_route_ctrl.sv
// car_route_ctrl: sequencing FSM for the line-following car (countdown, straight, junction decode, turns, stop/error).
module car_route_ctrl #(
  parameter int COUNT_CYCLES    = 300_000_000,
  parameter int NUM_JUNCTIONS   = 4,
  parameter int LOST_CYCLES     = 50_000_000,
  parameter int TURN_MIN_CYCLES = 20_000_000,
  parameter int TURN_MAX_CYCLES = 200_000_000
) (
  input logic clk,
  input logic rst,
  car_route_if.slave bus
);
  localparam int MAX_A = COUNT_CYCLES > LOST_CYCLES ? COUNT_CYCLES : LOST_CYCLES;
  localparam int MAX_P = MAX_A > TURN_MAX_CYCLES ? MAX_A : TURN_MAX_CYCLES;
  localparam int TW = $clog2(MAX_P + 1);
  typedef enum logic [4:0] {
    IDLE = 5'd0, START = 5'd1, COUNT = 5'd2, STRAIGHT = 5'd3, CHOOSE = 5'd4,
    TURN_STRAIGHT = 5'd5, TURN_LEFT = 5'd6, TURN_RIGHT = 5'd7, STOP = 5'd30, ERROR = 5'd31
  } state_t;
  state_t state, nxt;
  logic [TW-1:0] timer, timer_n, lost, lost_n;
  logic [3:0] jidx, jidx_n;
  logic [1:0] entry;
  logic busy, busy_n, moving, turning;
  // one extra index bit so the saturated value NUM_JUNCTIONS fits even when it is 8
  assign entry = 2'(bus.route >> {jidx, 1'b0});
  assign turning = state inside {TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT};
  assign moving = turning || state inside {COUNT, STRAIGHT, CHOOSE};
  always_comb begin
    nxt = state;
    timer_n = timer;
    lost_n = lost;
    jidx_n = jidx;
    case (state)
      IDLE: nxt = bus.start ? START : IDLE;
      START: begin
        nxt = COUNT;
        timer_n = '0;
        lost_n = '0;
        jidx_n = '0;
      end
      COUNT: begin
        nxt = timer == TW'(COUNT_CYCLES - 1) ? STRAIGHT : COUNT;
        timer_n = timer == TW'(COUNT_CYCLES - 1) ? '0 : timer + 1'b1;
      end
      STRAIGHT: begin
        nxt = bus.sensor == 3'b111 ? CHOOSE :
              (bus.sensor == 3'b000 && lost == TW'(LOST_CYCLES - 1)) ? ERROR : STRAIGHT;
        lost_n = bus.sensor == 3'b111 ? lost : bus.sensor == 3'b000 ? lost + 1'b1 : '0;
      end
      CHOOSE: begin
        timer_n = '0;
        nxt = jidx >= 4'(NUM_JUNCTIONS) ? STOP :
              entry == 2'b00 ? TURN_STRAIGHT :
              entry == 2'b01 ? TURN_LEFT :
              entry == 2'b10 ? TURN_RIGHT : STOP;
      end
      TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT: begin
        timer_n = timer + 1'b1;
        if (timer >= TW'(TURN_MIN_CYCLES - 1) && bus.sensor == 3'b010) begin
          nxt = STRAIGHT;
          timer_n = '0;
          lost_n = '0;
          jidx_n = jidx == 4'(NUM_JUNCTIONS) ? jidx : jidx + 1'b1;
        end else if (timer == TW'(TURN_MAX_CYCLES - 1)) begin
          nxt = ERROR;
        end
      end
      STOP, ERROR: nxt = bus.start ? IDLE : state;
      default: nxt = IDLE;
    endcase
    if (moving && bus.abort) nxt = STOP;
  end
  assign busy_n = nxt inside {COUNT, STRAIGHT, CHOOSE, TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      lost <= '0;
      jidx <= '0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      timer <= timer_n;
      lost <= lost_n;
      jidx <= jidx_n;
      busy <= busy_n;
    end
  end
  assign bus.mode = state;
  assign bus.junction_idx = jidx[2:0];
  assign bus.busy = busy;
endmodule

// File: tb/tb_car_route_ctrl.sv
// tb_car_route_ctrl: directed scoreboard bench; each step queues the expected {mode, junction_idx, busy} and checks it after the edge.
module tb_car_route_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [8:0] sb[$];
  car_route_if #(.NUM_JUNCTIONS(3)) bus();
  car_route_ctrl #(
    .COUNT_CYCLES(10), .NUM_JUNCTIONS(3), .LOST_CYCLES(8),
    .TURN_MIN_CYCLES(4), .TURN_MAX_CYCLES(50)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick(input logic [4:0] m, input logic [2:0] j, input logic b, input string tag);
    logic [8:0] exp, obs;
    sb.push_back({m, j, b});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    obs = {bus.mode, bus.junction_idx, bus.busy};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: mode/idx/busy got %0d/%0d/%0d expected %0d/%0d/%0d",
             tag, obs[8:4], obs[3:1], obs[0], exp[8:4], exp[3:1], exp[0]);
    end
  endtask
  task automatic go(input logic [2:0] j0);
    bus.sensor = 3'b010;
    bus.start = 1'b1;
    tick(5'd1, j0, 1'b0, "start");
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick(5'd2, 3'd0, 1'b1, "count");
    tick(5'd3, 3'd0, 1'b1, "count_done");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sensor = 3'b010;
    bus.route = 6'b111001;
    tick(5'd0, 3'd0, 1'b0, "reset");
    tick(5'd0, 3'd0, 1'b0, "reset_hold");
    rst = 1'b0;
    tick(5'd0, 3'd0, 1'b0, "idle");
    go(3'd0);
    bus.start = 1'b1;
    tick(5'd3, 3'd0, 1'b1, "start_ignored");
    bus.start = 1'b0;
    bus.sensor = 3'b111;
    tick(5'd4, 3'd0, 1'b1, "choose0");
    tick(5'd6, 3'd0, 1'b1, "left_enter");
    tick(5'd6, 3'd0, 1'b1, "left_111_ignored");
    bus.sensor = 3'b010;
    tick(5'd6, 3'd0, 1'b1, "left_min1");
    tick(5'd6, 3'd0, 1'b1, "left_min2");
    tick(5'd3, 3'd1, 1'b1, "left_exit");
    bus.sensor = 3'b111;
    tick(5'd4, 3'd1, 1'b1, "choose1");
    bus.sensor = 3'b010;
    for (int i = 0; i < 4; i++) tick(5'd7, 3'd1, 1'b1, "right");
    tick(5'd3, 3'd2, 1'b1, "right_exit");
    bus.sensor = 3'b111;
    tick(5'd4, 3'd2, 1'b1, "choose2");
    tick(5'd30, 3'd2, 1'b0, "route_stop");
    tick(5'd30, 3'd2, 1'b0, "stop_hold");
    bus.start = 1'b1;
    tick(5'd0, 3'd2, 1'b0, "stop_to_idle");
    bus.start = 1'b0;
    go(3'd2);
    bus.sensor = 3'b000;
    for (int i = 0; i < 7; i++) tick(5'd3, 3'd0, 1'b1, "lost7");
    bus.sensor = 3'b010;
    tick(5'd3, 3'd0, 1'b1, "lost_clear");
    bus.sensor = 3'b000;
    for (int i = 0; i < 7; i++) tick(5'd3, 3'd0, 1'b1, "lost8");
    tick(5'd31, 3'd0, 1'b0, "lost_error");
    bus.start = 1'b1;
    tick(5'd0, 3'd0, 1'b0, "error_to_idle");
    bus.start = 1'b0;
    bus.route = 6'b000010;
    go(3'd0);
    bus.sensor = 3'b111;
    tick(5'd4, 3'd0, 1'b1, "to_choose");
    bus.sensor = 3'b000;
    for (int i = 0; i < 50; i++) tick(5'd7, 3'd0, 1'b1, "turn_wait");
    tick(5'd31, 3'd0, 1'b0, "turn_timeout");
    bus.start = 1'b1;
    tick(5'd0, 3'd0, 1'b0, "timeout_idle");
    tick(5'd1, 3'd0, 1'b0, "abort_start");
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick(5'd2, 3'd0, 1'b1, "abort_count");
    bus.abort = 1'b1;
    tick(5'd30, 3'd0, 1'b0, "abort_wins");
    tick(5'd30, 3'd0, 1'b0, "abort_in_stop");
    bus.abort = 1'b0;
    bus.start = 1'b1;
    tick(5'd0, 3'd0, 1'b0, "abort_idle");
    bus.start = 1'b0;
    bus.route = 6'b000100;
    go(3'd0);
    bus.sensor = 3'b111;
    tick(5'd4, 3'd0, 1'b1, "rst_choose0");
    bus.sensor = 3'b010;
    for (int i = 0; i < 4; i++) tick(5'd5, 3'd0, 1'b1, "rst_tstraight");
    tick(5'd3, 3'd1, 1'b1, "rst_exit");
    bus.sensor = 3'b111;
    tick(5'd4, 3'd1, 1'b1, "rst_choose1");
    bus.sensor = 3'b000;
    tick(5'd6, 3'd1, 1'b1, "rst_left");
    tick(5'd6, 3'd1, 1'b1, "rst_left2");
    rst = 1'b1;
    tick(5'd0, 3'd0, 1'b0, "rst_mid");
    rst = 1'b0;
    bus.route = 6'b000000;
    go(3'd0);
    for (int k = 0; k < 3; k++) begin
      bus.sensor = 3'b111;
      tick(5'd4, 3'(k), 1'b1, "exh_choose");
      bus.sensor = 3'b010;
      for (int i = 0; i < 4; i++) tick(5'd5, 3'(k), 1'b1, "exh_turn");
      tick(5'd3, 3'(k + 1), 1'b1, "exh_exit");
    end
    bus.sensor = 3'b111;
    tick(5'd4, 3'd3, 1'b1, "exh_choose3");
    tick(5'd30, 3'd3, 1'b0, "exhausted_stop");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
